vault_lockout_ctrl: RTL and testbench

Downstream consumer of the registered PIN-compare result (`Valid`) in the banking safety path. Turns each submitted PIN attempt into a vault action:
- opens the vault for a bounded hold time on a match;
- counts consecutive mismatches and enforces a timed lockout after too many;
- latches a terminal alarm after repeated lockouts.

It sits between the PIN checker and the vault actuator/status LEDs.

---
 rtl/vault_pkg.sv | 16 +
 rtl/vault_timer.sv | 28 ++
 rtl/vault_lockout_ctrl.sv | 120 ++++++++++++
 tb/tb_vault_lockout_ctrl.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vault_pkg.sv
// Shared types and default parameters for the vault lockout controller.
package vault_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OPEN   = 2'd1,
    LOCKED = 2'd2,
    ALARM  = 2'd3
  } vault_state_t;

  localparam int unsigned DEF_MAX_FAILS      = 3;
  localparam int unsigned DEF_OPEN_CYCLES    = 16;
  localparam int unsigned DEF_LOCK_CYCLES    = 64;
  localparam int unsigned DEF_ALARM_LOCKOUTS = 2;

endpackage

// File: rtl/vault_timer.sv
// Loadable down-counter shared by the OPEN hold and the LOCKED lockout;
// it stops at zero and flags it.
module vault_timer #(
  parameter int unsigned WIDTH = 6
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_value,
  input  logic             i_en,
  output logic             o_zero
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_value;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/vault_lockout_ctrl.sv
// Turns PIN-compare results into vault actions: timed open on match,
// timed lockout after consecutive mismatches, terminal alarm after repeated lockouts.
module vault_lockout_ctrl
  import vault_pkg::*;
#(
  parameter int unsigned MAX_FAILS      = DEF_MAX_FAILS,
  parameter int unsigned OPEN_CYCLES    = DEF_OPEN_CYCLES,
  parameter int unsigned LOCK_CYCLES    = DEF_LOCK_CYCLES,
  parameter int unsigned ALARM_LOCKOUTS = DEF_ALARM_LOCKOUTS
) (
  input  logic                             ClockSource,
  input  logic                             ResetN,
  input  logic                             Attempt,
  input  logic                             Valid,
  input  logic                             CloseReq,
  output logic                             VaultOpen,
  output logic                             Locked,
  output logic                             Alarm,
  output logic [$clog2(MAX_FAILS+1)-1:0]   FailCount
);

  localparam int unsigned FAIL_W    = $clog2(MAX_FAILS + 1);
  localparam int unsigned LOCKOUT_W = $clog2(ALARM_LOCKOUTS + 1);
  localparam int unsigned TIMER_MAX = (OPEN_CYCLES > LOCK_CYCLES) ? OPEN_CYCLES : LOCK_CYCLES;
  localparam int unsigned TIMER_W   = (TIMER_MAX > 1) ? $clog2(TIMER_MAX) : 1;

  vault_state_t         r_state;
  vault_state_t         w_next_state;
  logic [FAIL_W-1:0]    r_fail_count;
  logic [LOCKOUT_W-1:0] r_lockouts;
  logic                 r_vault_open;
  logic                 r_locked;
  logic                 r_alarm;

  logic                 w_load;
  logic [TIMER_W-1:0]   w_load_value;
  logic                 w_timer_en;
  logic                 w_timer_zero;
  logic                 w_fail_hit;
  logic                 w_alarm_hit;
  logic                 w_idle_attempt;

  assign w_fail_hit     = (r_fail_count == FAIL_W'(MAX_FAILS - 1));
  assign w_alarm_hit    = (r_lockouts == LOCKOUT_W'(ALARM_LOCKOUTS - 1));
  assign w_idle_attempt = (r_state == IDLE) && Attempt;
  assign w_timer_en     = (r_state == OPEN) || (r_state == LOCKED);

  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_load_value = '0;
    case (r_state)
      IDLE: begin
        if (Attempt) begin
          if (Valid) begin
            w_next_state = OPEN;
            w_load       = 1'b1;
            w_load_value = TIMER_W'(OPEN_CYCLES - 1);
          end else if (w_fail_hit) begin
            if (w_alarm_hit) begin
              w_next_state = ALARM;
            end else begin
              w_next_state = LOCKED;
              w_load       = 1'b1;
              w_load_value = TIMER_W'(LOCK_CYCLES - 1);
            end
          end
        end
      end
      OPEN:    if (w_timer_zero || CloseReq) w_next_state = IDLE;
      LOCKED:  if (w_timer_zero) w_next_state = IDLE;
      default: w_next_state = ALARM;
    endcase
  end

  // Outputs are registered from the next state so they line up with r_state.
  always_ff @(posedge ClockSource) begin
    if (!ResetN) begin
      r_state      <= IDLE;
      r_fail_count <= '0;
      r_lockouts   <= '0;
      r_vault_open <= 1'b0;
      r_locked     <= 1'b0;
      r_alarm      <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_vault_open <= (w_next_state == OPEN);
      r_locked     <= (w_next_state == LOCKED) || (w_next_state == ALARM);
      r_alarm      <= (w_next_state == ALARM);
      if (w_idle_attempt) begin
        if (Valid) begin
          r_fail_count <= '0;
          r_lockouts   <= '0;
        end else if (w_fail_hit) begin
          r_fail_count <= '0;
          r_lockouts   <= r_lockouts + 1'b1;
        end else begin
          r_fail_count <= r_fail_count + 1'b1;
        end
      end
    end
  end

  vault_timer #(
    .WIDTH (TIMER_W)
  ) u_timer (
    .i_clk        (ClockSource),
    .i_rst_n      (ResetN),
    .i_load       (w_load),
    .i_load_value (w_load_value),
    .i_en         (w_timer_en),
    .o_zero       (w_timer_zero)
  );

  assign VaultOpen = r_vault_open;
  assign Locked    = r_locked;
  assign Alarm     = r_alarm;
  assign FailCount = r_fail_count;

endmodule

// File: tb/tb_vault_lockout_ctrl.sv
// Directed bench for vault_lockout_ctrl with default parameters.
module tb_vault_lockout_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       attempt = 1'b0;
  logic       valid = 1'b0;
  logic       close_req = 1'b0;
  logic       vault_open;
  logic       locked;
  logic       alarm;
  logic [1:0] fail_count;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  vault_lockout_ctrl #(
    .MAX_FAILS      (3),
    .OPEN_CYCLES    (16),
    .LOCK_CYCLES    (64),
    .ALARM_LOCKOUTS (2)
  ) dut (
    .ClockSource (clk),
    .ResetN      (rst_n),
    .Attempt     (attempt),
    .Valid       (valid),
    .CloseReq    (close_req),
    .VaultOpen   (vault_open),
    .Locked      (locked),
    .Alarm       (alarm),
    .FailCount   (fail_count)
  );

  // After tick(), the outputs shown belong to the cycle following the edge.
  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_attempt(input logic v);
    attempt = 1'b1;
    valid   = v;
    tick();
    attempt = 1'b0;
    valid   = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    total++;
    if ({vault_open, locked, alarm, fail_count} !== 5'b0) begin
      bad++;
      $display("FAIL reset_outputs open=%b locked=%b alarm=%b fails=%0d exp all 0",
               vault_open, locked, alarm, fail_count);
    end
  endtask

  task automatic test_open_hold();
    do_reset();
    do_attempt(1'b1);
    for (int i = 1; i <= 16; i++) begin
      total++;
      if (vault_open !== 1'b1 || locked !== 1'b0 || fail_count !== 2'd0) begin
        bad++;
        $display("FAIL open_hold cyc=N+%0d open=%b locked=%b fails=%0d exp 1/0/0",
                 i, vault_open, locked, fail_count);
      end
      if (i == 16) begin
        attempt = 1'b1;
        valid   = 1'b0;
      end
      tick();
      attempt = 1'b0;
    end
    total++;
    if (vault_open !== 1'b0 || fail_count !== 2'd0) begin
      bad++;
      $display("FAIL open_expiry open=%b fails=%0d exp 0/0", vault_open, fail_count);
    end
  endtask

  task automatic test_close_req();
    do_reset();
    do_attempt(1'b1);
    tick(2);
    do_attempt(1'b0);
    total++;
    if (fail_count !== 2'd0 || vault_open !== 1'b1) begin
      bad++;
      $display("FAIL open_ignores_attempt fails=%0d open=%b exp 0/1", fail_count, vault_open);
    end
    tick();
    close_req = 1'b1;
    total++;
    if (vault_open !== 1'b1) begin
      bad++;
      $display("FAIL close_same_cycle open=%b exp 1", vault_open);
    end
    tick();
    close_req = 1'b0;
    total++;
    if (vault_open !== 1'b0 || fail_count !== 2'd0) begin
      bad++;
      $display("FAIL close_next_cycle open=%b fails=%0d exp 0/0", vault_open, fail_count);
    end
  endtask

  task automatic test_lockout();
    logic [1:0] exp_fc [3];
    exp_fc[0] = 2'd1;
    exp_fc[1] = 2'd2;
    exp_fc[2] = 2'd0;
    do_reset();
    for (int j = 0; j < 3; j++) begin
      do_attempt(1'b0);
      total++;
      if (fail_count !== exp_fc[j] || locked !== (j == 2)) begin
        bad++;
        $display("FAIL lockout_count step=%0d fails=%0d locked=%b exp %0d/%b",
                 j, fail_count, locked, exp_fc[j], (j == 2));
      end
      if (j < 2) tick();
    end
    for (int i = 5; i <= 68; i++) begin
      total++;
      if (locked !== 1'b1 || alarm !== 1'b0 || vault_open !== 1'b0) begin
        bad++;
        $display("FAIL lockout_hold cyc=N+%0d locked=%b alarm=%b open=%b exp 1/0/0",
                 i, locked, alarm, vault_open);
      end
      if (i == 30) begin
        attempt = 1'b1;
        valid   = 1'b0;
      end
      tick();
      attempt = 1'b0;
    end
    total++;
    if (locked !== 1'b0 || fail_count !== 2'd0) begin
      bad++;
      $display("FAIL lockout_release locked=%b fails=%0d exp 0/0", locked, fail_count);
    end
    do_attempt(1'b1);
    total++;
    if (vault_open !== 1'b1) begin
      bad++;
      $display("FAIL open_after_lockout open=%b exp 1", vault_open);
    end
  endtask

  task automatic test_alarm();
    do_reset();
    repeat (3) do_attempt(1'b0);
    tick(64);
    total++;
    if (locked !== 1'b0 || alarm !== 1'b0) begin
      bad++;
      $display("FAIL alarm_first_release locked=%b alarm=%b exp 0/0", locked, alarm);
    end
    repeat (3) do_attempt(1'b0);
    total++;
    if (alarm !== 1'b1 || locked !== 1'b1 || vault_open !== 1'b0 || fail_count !== 2'd0) begin
      bad++;
      $display("FAIL alarm_entry alarm=%b locked=%b open=%b fails=%0d exp 1/1/0/0",
               alarm, locked, vault_open, fail_count);
    end
    do_attempt(1'b1);
    tick(100);
    total++;
    if (alarm !== 1'b1 || locked !== 1'b1 || vault_open !== 1'b0) begin
      bad++;
      $display("FAIL alarm_sticky alarm=%b locked=%b open=%b exp 1/1/0", alarm, locked, vault_open);
    end
    do_reset();
    total++;
    if ({vault_open, locked, alarm, fail_count} !== 5'b0) begin
      bad++;
      $display("FAIL alarm_reset open=%b locked=%b alarm=%b fails=%0d exp all 0",
               vault_open, locked, alarm, fail_count);
    end
  endtask

  task automatic test_match_clears();
    do_reset();
    repeat (3) do_attempt(1'b0);
    tick(64);
    do_attempt(1'b0);
    do_attempt(1'b0);
    total++;
    if (fail_count !== 2'd2) begin
      bad++;
      $display("FAIL clear_pre_match fails=%0d exp 2", fail_count);
    end
    do_attempt(1'b1);
    total++;
    if (fail_count !== 2'd0 || vault_open !== 1'b1) begin
      bad++;
      $display("FAIL clear_on_match fails=%0d open=%b exp 0/1", fail_count, vault_open);
    end
    close_req = 1'b1;
    tick();
    close_req = 1'b0;
    repeat (3) do_attempt(1'b0);
    total++;
    if (locked !== 1'b1 || alarm !== 1'b0) begin
      bad++;
      $display("FAIL clear_locks_not_alarm locked=%b alarm=%b exp 1/0", locked, alarm);
    end
  endtask

  task automatic test_reset_during_open();
    do_reset();
    do_attempt(1'b1);
    tick(3);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    total++;
    if ({vault_open, locked, alarm, fail_count} !== 5'b0) begin
      bad++;
      $display("FAIL reset_mid_open open=%b locked=%b alarm=%b fails=%0d exp all 0",
               vault_open, locked, alarm, fail_count);
    end
    do_attempt(1'b0);
    total++;
    if (fail_count !== 2'd1 || vault_open !== 1'b0) begin
      bad++;
      $display("FAIL idle_after_reset fails=%0d open=%b exp 1/0", fail_count, vault_open);
    end
    rst_n   = 1'b0;
    attempt = 1'b1;
    valid   = 1'b1;
    tick();
    rst_n   = 1'b1;
    attempt = 1'b0;
    valid   = 1'b0;
    total++;
    if (vault_open !== 1'b0 || fail_count !== 2'd0) begin
      bad++;
      $display("FAIL reset_beats_attempt open=%b fails=%0d exp 0/0", vault_open, fail_count);
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_open_hold();
    test_close_req();
    test_lockout();
    test_alarm();
    test_match_clears();
    test_reset_during_open();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
